// File: rtl/jamma_input_scanner.sv
// Purpose : scans the multiplexed JAMMA player bus (JSELECT + shared JJOY),
//           debounces player 1/2 and coin bits, and stretches coin pulses.
// Latency : a stable pin change reaches O_JOYx/O_COIN on the edge after the
//           DB_COUNT-th agreeing sample; one scan is 2*(SETTLE+1) cycles.
// Backpr. : none; free-running scan, O_SCAN_DONE strobes once per scan.
//
// Ports:
//   I_CLK, I_RESET_N       pclk and synchronous active-low reset
//   I_JJOY[7:0]            shared player bus (async, active-low)
//   I_JCOIN[1:0]           coin switches (async, active-low)
//   I_KBD_JOY[5:0]         keyboard joystick (sync, active-low), merged into P1
//   O_JSELECT              0 = player 1 on the bus, 1 = player 2
//   O_JOY1/O_JOY2[7:0]     debounced players (P1 ANDed with keyboard)
//   O_COIN[1:0]            debounced, stretched coins (active-low)
//   O_SCAN_DONE            one-cycle strobe after each committed P1+P2 scan
module jamma_input_scanner #(
  parameter int SETTLE    = 4,
  parameter int DB_COUNT  = 3,
  parameter int COIN_HOLD = 8
) (
  input  logic       I_CLK,
  input  logic       I_RESET_N,
  input  logic [7:0] I_JJOY,
  input  logic [1:0] I_JCOIN,
  input  logic [5:0] I_KBD_JOY,
  output logic       O_JSELECT,
  output logic [7:0] O_JOY1,
  output logic [7:0] O_JOY2,
  output logic [1:0] O_COIN,
  output logic       O_SCAN_DONE
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);
  localparam logic [3:0] DB_LAST     = 4'(DB_COUNT - 1);
  localparam logic [7:0] HOLD_LOAD   = 8'(COIN_HOLD);

  typedef enum logic [1:0] {SEL_A, SAMP_A, SEL_B, SAMP_B} state_t;

  state_t     state, state_nxt;
  logic [7:0] settle_cnt, settle_nxt;

  // two-flop synchronizers; idle (released) level is 1
  logic [7:0] jjoy_s1, jjoy_s2;
  logic [1:0] jcoin_s1, jcoin_s2;

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      jjoy_s1  <= '1;
      jjoy_s2  <= '1;
      jcoin_s1 <= '1;
      jcoin_s2 <= '1;
    end else begin
      jjoy_s1  <= I_JJOY;
      jjoy_s2  <= jjoy_s1;
      jcoin_s1 <= I_JCOIN;
      jcoin_s2 <= jcoin_s1;
    end
  end

  // scan sequencer
  always_comb begin
    state_nxt  = state;
    settle_nxt = settle_cnt;
    case (state)
      SEL_A: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = SAMP_A;
        else                           settle_nxt = settle_cnt + 8'd1;
      end
      SAMP_A: begin
        settle_nxt = '0;
        state_nxt  = SEL_B;
      end
      SEL_B: begin
        if (settle_cnt == SETTLE_LAST) state_nxt = SAMP_B;
        else                           settle_nxt = settle_cnt + 8'd1;
      end
      SAMP_B: begin
        settle_nxt = '0;
        state_nxt  = SEL_A;
      end
      default: begin
        settle_nxt = '0;
        state_nxt  = SEL_A;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      state       <= SEL_A;
      settle_cnt  <= '0;
      O_JSELECT   <= 1'b0;
      O_SCAN_DONE <= 1'b0;
    end else begin
      state       <= state_nxt;
      settle_cnt  <= settle_nxt;
      // select follows the state being entered, so the bus starts settling
      // in the very first cycle of SEL_A/SEL_B
      O_JSELECT   <= (state_nxt == SEL_B) || (state_nxt == SAMP_B);
      O_SCAN_DONE <= (state == SAMP_B);
    end
  end

  // debounce: bits [7:0] P1, [15:8] P2, [17:16] coin
  logic [17:0] raw, deb, en, commit;
  logic [3:0]  agree [18];

  assign raw = {jcoin_s2, jjoy_s2, jjoy_s2};
  assign en  = {{10{state == SAMP_B}}, {8{state == SAMP_A}}};

  always_comb begin
    commit = '0;
    for (int i = 0; i < 18; i++)
      commit[i] = en[i] && (raw[i] != deb[i]) && (agree[i] == DB_LAST);
  end

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      deb <= '1;
      for (int i = 0; i < 18; i++) agree[i] <= '0;
    end else begin
      for (int i = 0; i < 18; i++) begin
        if (en[i]) begin
          if (commit[i]) begin
            deb[i]   <= raw[i];
            agree[i] <= '0;
          end else if (raw[i] == deb[i]) begin
            agree[i] <= '0;
          end else begin
            agree[i] <= agree[i] + 4'd1;
          end
        end
      end
    end
  end

  // coin stretch: a debounced press holds the output low for at least
  // COIN_HOLD scans; a fresh press reloads even if the hold is expiring
  logic [7:0] hold [2];
  logic [1:0] coin_fall;

  assign coin_fall = commit[17:16] & ~raw[17:16];

  always_ff @(posedge I_CLK) begin
    if (!I_RESET_N) begin
      hold[0] <= '0;
      hold[1] <= '0;
    end else if (state == SAMP_B) begin
      for (int c = 0; c < 2; c++) begin
        if (coin_fall[c])       hold[c] <= HOLD_LOAD;
        else if (hold[c] != '0) hold[c] <= hold[c] - 8'd1;
      end
    end
  end

  assign O_COIN[0] = deb[16] & (hold[0] == '0);
  assign O_COIN[1] = deb[17] & (hold[1] == '0);
  assign O_JOY1    = deb[7:0] & {2'b11, I_KBD_JOY};
  assign O_JOY2    = deb[15:8];

endmodule

// File: tb/tb_jamma_input_scanner.sv
module tb_jamma_input_scanner;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] p1_pins = 8'hFF;
  logic [7:0] p2_pins = 8'hFF;
  logic [1:0] coin_pins = 2'b11;
  logic [5:0] kbd = 6'h3F;
  logic [7:0] jjoy;
  logic       jsel;
  logic [7:0] joy1, joy2;
  logic [1:0] coin;
  logic       done;

  // board model: the bus shows whichever player JSELECT picks
  assign jjoy = jsel ? p2_pins : p1_pins;

  always #5 clk = ~clk;

  jamma_input_scanner #(.SETTLE(4), .DB_COUNT(3), .COIN_HOLD(8)) dut (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_JJOY(jjoy), .I_JCOIN(coin_pins),
    .I_KBD_JOY(kbd), .O_JSELECT(jsel), .O_JOY1(joy1), .O_JOY2(joy2),
    .O_COIN(coin), .O_SCAN_DONE(done)
  );

  typedef struct packed {
    logic [7:0] j1;
    logic [7:0] j2;
    logic [1:0] c;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   last_done = -1;
  bit   skip_period = 1'b0;

  always @(posedge clk) cycle++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cycle);
    end
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 40);
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL scan_timeout: no O_SCAN_DONE within %0d cycles", n);
    end
  endtask

  // present one scan's pins, queue its hand-computed outputs, wait for commit
  task automatic scan(input logic [7:0] p1, input logic [7:0] p2, input logic [1:0] c,
                      input logic [7:0] e1, input logic [7:0] e2, input logic [1:0] ec);
    exp_t e;
    p1_pins   = p1;
    p2_pins   = p2;
    coin_pins = c;
    e.j1 = e1;
    e.j2 = e2;
    e.c  = ec;
    exp_q.push_back(e);
    wait_done();
  endtask

  // monitor: every scan strobe pops one expected entry
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_scan: strobe with empty queue at cycle %0d", cycle);
        end else begin
          e = exp_q.pop_front();
          check("scan_joy1", 32'(joy1), 32'(e.j1));
          check("scan_joy2", 32'(joy2), 32'(e.j2));
          check("scan_coin", 32'(coin), 32'(e.c));
        end
        if (last_done >= 0 && !skip_period)
          check("scan_period", 32'(cycle - last_done), 32'd10);
        last_done   = cycle;
        skip_period = 1'b0;
      end
    end
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_joy1", 32'(joy1), 32'hFF);
    check("rst_joy2", 32'(joy2), 32'hFF);
    check("rst_coin", 32'(coin), 32'h3);
    check("rst_jsel", 32'(jsel), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst_n = 1'b1;

    // idle, then P1 up pressed: commits on the 3rd SAMP_A
    scan(8'hFF, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);
    scan(8'hFE, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);
    scan(8'hFE, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);
    scan(8'hFE, 8'hFF, 2'b11, 8'hFE, 8'hFF, 2'b11);
    // P2 bit 4: 1-scan glitch, then a 2-scan glitch; neither commits
    scan(8'hFE, 8'hEF, 2'b11, 8'hFE, 8'hFF, 2'b11);
    scan(8'hFE, 8'hFF, 2'b11, 8'hFE, 8'hFF, 2'b11);
    scan(8'hFE, 8'hEF, 2'b11, 8'hFE, 8'hFF, 2'b11);
    scan(8'hFE, 8'hEF, 2'b11, 8'hFE, 8'hFF, 2'b11);
    scan(8'hFE, 8'hFF, 2'b11, 8'hFE, 8'hFF, 2'b11);
    // P1 released; coin 0 low for exactly 3 scans
    scan(8'hFF, 8'hFF, 2'b10, 8'hFE, 8'hFF, 2'b11);
    scan(8'hFF, 8'hFF, 2'b10, 8'hFE, 8'hFF, 2'b11);
    scan(8'hFF, 8'hFF, 2'b10, 8'hFF, 8'hFF, 2'b10);
    // hold loaded with 8 at the commit, counts down one per scan
    for (int k = 0; k < 7; k++)
      scan(8'hFF, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b10);
    scan(8'hFF, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);
    scan(8'hFF, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);

    // keyboard merge is combinational
    kbd = 6'b111101;
    #1;
    check("kbd_joy1", 32'(joy1), 32'hFD);
    check("kbd_joy2", 32'(joy2), 32'hFF);
    kbd = 6'h3F;
    #1;
    check("kbd_restore", 32'(joy1), 32'hFF);

    // get P1 debounced to FE, then reset mid SEL_B
    scan(8'hFE, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);
    scan(8'hFE, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);
    scan(8'hFE, 8'hFF, 2'b11, 8'hFE, 8'hFF, 2'b11);
    n = 0;
    while (!jsel && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("reach_sel_b", 32'(jsel), 32'h1);
    @(negedge clk);
    rst_n       = 1'b0;
    skip_period = 1'b1;
    @(negedge clk);
    check("midrst_joy1", 32'(joy1), 32'hFF);
    check("midrst_joy2", 32'(joy2), 32'hFF);
    check("midrst_coin", 32'(coin), 32'h3);
    check("midrst_jsel", 32'(jsel), 32'h0);
    check("midrst_done", 32'(done), 32'h0);
    rst_n   = 1'b1;
    p1_pins = 8'hFF;
    begin
      exp_t e;
      e.j1 = 8'hFF;
      e.j2 = 8'hFF;
      e.c  = 2'b11;
      exp_q.push_back(e);
    end
    // first SAMP_A is cycle 4; JSELECT rises on the edge leaving it
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check("post_rst_jsel", 32'(jsel), (i == 5) ? 32'h1 : 32'h0);
    end
    wait_done();
    scan(8'hFF, 8'hFF, 2'b11, 8'hFF, 8'hFF, 2'b11);
    @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
